// File: rtl/sm_sub_pipe.sv
// sm_sub_pipe: two-stage pipelined sign-magnitude subtractor, diff = a - b.
// Operands and result are {sign, magnitude[numwidth-1:0]}; sign 1 = negative.
// Valid/ready on both sides, one result per cycle, synchronous active-low reset.
// Build option: define SM_SUB_SAT_EN to saturate the magnitude on same-sign
// overflow; otherwise the magnitude wraps. ovf is raised in both builds.
module sm_sub_pipe #(
  parameter int numwidth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [numwidth:0]   a,
  input  logic [numwidth:0]   b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [numwidth:0]   diff,
  output logic                ovf,
  output logic                busy
);

  logic                w_s1_adv;
  logic                w_s2_adv;
  logic                w_s_eff_b;
  logic [numwidth:0]   w_sum;
  logic [numwidth-1:0] w_mag;
  logic                w_sign;
  logic                w_ovf;

  logic                r_s1_valid;
  logic                r_s1_sa;
  logic                r_s1_sb;
  logic                r_s1_eqs;
  logic                r_s1_agt;
  logic [numwidth-1:0] r_s1_ma;
  logic [numwidth-1:0] r_s1_mb;

  logic                r_s2_valid;
  logic [numwidth:0]   r_diff;
  logic                r_ovf;

  // A stage may advance when it is empty or the stage after it is moving.
  assign w_s2_adv  = !r_s2_valid | out_ready;
  assign w_s1_adv  = !r_s1_valid | w_s2_adv;
  assign in_ready  = rst_n & w_s1_adv;

  assign out_valid = r_s2_valid;
  assign diff      = r_diff;
  assign ovf       = r_ovf;
  assign busy      = r_s1_valid | r_s2_valid;

  // Subtraction is addition of b with its sign flipped.
  assign w_s_eff_b = ~b[numwidth];

  // Stage 1: capture signs, magnitudes, sign-equality and magnitude compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sa    <= 1'b0;
      r_s1_sb    <= 1'b0;
      r_s1_eqs   <= 1'b0;
      r_s1_agt   <= 1'b0;
      r_s1_ma    <= '0;
      r_s1_mb    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sa  <= a[numwidth];
        r_s1_sb  <= w_s_eff_b;
        r_s1_eqs <= (a[numwidth] == w_s_eff_b);
        r_s1_agt <= (a[numwidth-1:0] > b[numwidth-1:0]);
        r_s1_ma  <= a[numwidth-1:0];
        r_s1_mb  <= b[numwidth-1:0];
      end
    end
  end

  assign w_sum = {1'b0, r_s1_ma} + {1'b0, r_s1_mb};

  // Stage 2 datapath: add or subtract magnitudes, then force zero positive.
  always_comb begin
    w_mag  = '0;
    w_sign = 1'b0;
    w_ovf  = 1'b0;
    if (r_s1_eqs) begin
      w_sign = r_s1_sa;
      w_ovf  = w_sum[numwidth];
`ifdef SM_SUB_SAT_EN
      w_mag  = w_sum[numwidth] ? '1 : w_sum[numwidth-1:0];
`else
      w_mag  = w_sum[numwidth-1:0];
`endif
    end else if (r_s1_agt) begin
      w_mag  = r_s1_ma - r_s1_mb;
      w_sign = r_s1_sa;
    end else begin
      // Equal magnitudes also land here and give zero.
      w_mag  = r_s1_mb - r_s1_ma;
      w_sign = r_s1_sb;
    end
    if (w_mag == '0) begin
      w_sign = 1'b0;
    end
  end

  // Stage 2 register: holds the result steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_ovf      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff <= {w_sign, w_mag};
        r_ovf  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_sm_sub_pipe.sv
// Testbench for sm_sub_pipe (numwidth = 16) with a scoreboard queue.
module tb_sm_sub_pipe;
  localparam int NW = 16;

  typedef struct {
    logic [NW:0] d;
    logic        o;
    int          c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [NW:0]   a = '0;
  logic [NW:0]   b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [NW:0]   diff;
  logic          ovf;
  logic          busy;

  exp_t          sb_q[$];
  int            ntests = 0;
  int            nfail = 0;
  int            cyc = 0;
  int            n_ret = 0;
  int            last_ret = 0;
  bit            lat_chk = 1'b0;
  logic          s_acc;
  logic          s_ret;
  logic [NW:0]   s_d;
  logic          s_o;

  sm_sub_pipe #(.numwidth(NW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: signed integer subtraction, then re-encode as sign-magnitude.
  function automatic exp_t model(input logic [NW:0] x, input logic [NW:0] y, input int c);
    int   va, vb, r, m;
    exp_t e;
    va = x[NW] ? -int'(x[NW-1:0]) : int'(x[NW-1:0]);
    vb = y[NW] ? -int'(y[NW-1:0]) : int'(y[NW-1:0]);
    r = va - vb;
    m = (r < 0) ? -r : r;
    e.o = (m > 65535);
`ifdef SM_SUB_SAT_EN
    if (e.o) m = 65535;
`else
    m = m & 32'h0000_FFFF;
`endif
    e.d = {((r < 0) && (m != 0)), m[NW-1:0]};
    e.c = c;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the drive point, then score at the edge.
  task automatic cycle();
    exp_t e;
    #1;
    s_acc = in_valid & in_ready;
    s_ret = out_valid & out_ready;
    s_d   = diff;
    s_o   = ovf;
    @(posedge clk);
    if (s_ret) begin
      check("out_has_expect", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("diff", 32'(s_d), 32'(e.d));
        check("ovf", 32'(s_o), 32'(e.o));
        if (lat_chk) check("latency", cyc, e.c + 2);
      end
      n_ret++;
      last_ret = cyc;
    end
    if (s_acc) sb_q.push_back(model(a, b, cyc));
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [NW:0] x, input logic [NW:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_acc) break;
    end
    check("send_accepted", 32'(s_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max; k++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      cycle();
    end
    check("drained", sb_q.size(), 0);
  endtask

  logic [NW:0] pa[4];
  logic [NW:0] pb[4];
  int          idx;
  int          n0;
  int          first;
  int          nacc;
  logic [NW:0] hold_d;

  initial begin
    pa = '{17'h00010, 17'h00020, 17'h10030, 17'h00004};
    pb = '{17'h00001, 17'h10002, 17'h00003, 17'h00040};
    @(negedge clk);

    // Reset state
    cycle();
    cycle();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic, mixed-sign and overflow cases, one at a time with latency check
    lat_chk = 1'b1;
    send(17'h00005, 17'h00003); drain(10);
    send(17'h00003, 17'h00005); drain(10);
    send(17'h10007, 17'h00009); drain(10);
    send(17'h00004, 17'h10006); drain(10);
    send(17'h01234, 17'h01234); drain(10);
    send(17'h10000, 17'h00000); drain(10);
    send(17'h0FFFF, 17'h10001); drain(10);
    send(17'h18000, 17'h08000); drain(10);
    send(17'h1FFFF, 17'h0FFFF); drain(10);

    // Backpressure: fill both stages, then release
    lat_chk = 1'b0;
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      a = pa[idx]; b = pb[idx]; in_valid = 1'b1;
      cycle();
      if (s_acc && idx < 3) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_diff_front", 32'(diff), 32'(model(pa[0], pb[0], 0).d));
    hold_d = diff;
    cycle();
    cycle();
    check("bp_diff_hold", 32'(diff), 32'(hold_d));
    check("bp_in_ready_hold", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    n0 = n_ret;
    for (int k = 0; k < 4; k++) begin
      if (idx < 4) begin
        a = pa[idx]; b = pb[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (s_acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_returns_back_to_back", n_ret - n0, 4);
    check("bp_all_accepted", idx, 4);
    drain(10);

    // Reset with two results in flight
    out_ready = 1'b0;
    send(17'h00100, 17'h00001);
    send(17'h00200, 17'h00002);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    cycle();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    sb_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = n_ret;
    for (int k = 0; k < 5; k++) cycle();
    check("mid_no_stale", n_ret - n0, 0);
    check("mid_out_valid_low", 32'(out_valid), 32'd0);

    // Throughput: 100 random pairs, one per cycle
    lat_chk = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    first = cyc;
    nacc = 0;
    n0 = n_ret;
    for (int i = 0; i < 100; i++) begin
      a = 17'($urandom_range(0, 32'h1FFFF));
      if (i % 10 == 3) b = a;
      else if (i % 10 == 7) b = {1'b0, a[NW-1:0]};
      else b = 17'($urandom_range(0, 32'h1FFFF));
      cycle();
      if (s_acc) nacc++;
    end
    in_valid = 1'b0;
    drain(10);
    check("tp_accepted", nacc, 100);
    check("tp_returned", n_ret - n0, 100);
    check("tp_span", last_ret - first, 101);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
